// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings and arbiter state encoding.
package sdram_pkg;

  localparam int unsigned CMD_W = 4;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_PREC  = 4'b0010;
  localparam cmd_t CMD_AREF  = 4'b0001;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_WRITE = 4'b0100;
  localparam cmd_t CMD_READ  = 4'b0101;
  localparam cmd_t CMD_MRS   = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: holds the pins on the init engine until init_end, then grants
// refresh first and write/read round-robin (or fixed write>read) one at a time.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  arb_state_e state_q, state_d;
  logic       last_wr_q, last_wr_d;
  logic       aref_en_d, wr_en_d, rd_en_d;

  cmd_t              cmd_mux;
  logic [BANK_W-1:0] ba_mux;
  logic [ADDR_W-1:0] addr_mux;

  // State, round-robin history and one-cycle start pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      aref_en   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      aref_en   <= aref_en_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
    end
  end

  // Next-state and grant decision
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    aref_en_d = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_d   = ST_AREF;
          aref_en_d = 1'b1;
        end else if (wr_req && (!rd_req || !((RR_EN != 0) && last_wr_q))) begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          last_wr_d = 1'b0;
        end
      end
      ST_AREF: begin
        if (aref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin mux follows the current owner with no added latency
  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '1;
    addr_mux = '1;
    case (state_q)
      ST_IDLE: begin
        cmd_mux  = init_cmd;
        ba_mux   = init_bank;
        addr_mux = init_addr;
      end
      ST_AREF: begin
        cmd_mux  = aref_cmd;
        ba_mux   = aref_bank;
        addr_mux = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = wr_cmd;
        ba_mux   = wr_bank;
        addr_mux = wr_addr;
      end
      ST_READ: begin
        cmd_mux  = rd_cmd;
        ba_mux   = rd_bank;
        addr_mux = rd_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '1;
        addr_mux = '1;
      end
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba     = ba_mux;
  assign sdram_addr   = addr_mux;
  assign sdram_dq_out = wr_sdram_data;
  assign sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;

endmodule
